// File: rtl/snitch_data_mem_pkg.sv
// rtl/snitch_data_mem_pkg.sv - shared types and helpers for the power-gated TCDM bank array
package snitch_data_mem_pkg;

    // Group power state; encoding is visible on grp_state_o.
    typedef enum logic [1:0] {
        PG_ACTIVE = 2'b00,
        PG_SLEEP  = 2'b01,
        PG_WAKE   = 2'b10
    } pg_state_e;

    // Default macro configuration types; integrators override through the top's type parameters.
    typedef logic [15:0] sram_cfg_default_t;

    typedef struct packed {
        sram_cfg_default_t tcdm;
    } sram_cfgs_default_t;

    // Number of independently gated groups.
    function automatic int unsigned calc_num_groups(input int unsigned total_banks,
                                                    input int unsigned banks_per_group);
        return total_banks / banks_per_group;
    endfunction

endpackage

// File: rtl/snitch_data_mem_pg_ctrl.sv
// rtl/snitch_data_mem_pg_ctrl.sv - one bank group's power FSM; SNITCH_DATA_MEM_PG_STATS_EN adds a sleep-cycle counter
module snitch_data_mem_pg_ctrl import snitch_data_mem_pkg::*; #(
    parameter int unsigned WakeupCycles  = 4,
    parameter int unsigned IdleThreshold = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sleep_en_i,
    input  logic        wake_i,
    input  logic        req_i,
    output logic        active_o,
    output logic        pwr_en_o,
    output logic        ret_o,
    output logic [1:0]  state_o,
    output logic [31:0] sleep_cnt_o
);

    localparam int unsigned IdleW = (IdleThreshold > 0) ? $clog2(IdleThreshold + 1) : 1;
    localparam int unsigned WakeW = (WakeupCycles > 1) ? $clog2(WakeupCycles) : 1;
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(IdleThreshold);
    localparam logic [WakeW-1:0] WakeLoad = WakeW'(WakeupCycles - 1);

    pg_state_e        state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= PG_ACTIVE;
            idle_q     <= '0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    // Next state; the idle count only runs in ACTIVE, and a request always beats the threshold hit.
    always_comb begin
        state_d    = state_q;
        idle_d     = '0;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            PG_ACTIVE: begin
                if (req_i || wake_i || !sleep_en_i) begin
                    idle_d = '0;
                end else if ((IdleThreshold != 0) && (idle_q == IdleMax)) begin
                    state_d = PG_SLEEP;
                end else if (idle_q != IdleMax) begin
                    idle_d = idle_q + 1'b1;
                end else begin
                    idle_d = idle_q;
                end
            end
            PG_SLEEP: begin
                if (req_i || wake_i) begin
                    state_d    = PG_WAKE;
                    wake_cnt_d = WakeLoad;
                end
            end
            PG_WAKE: begin
                if (wake_cnt_q == '0) begin
                    state_d = PG_ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q - 1'b1;
                end
            end
            default: state_d = PG_ACTIVE;
        endcase
    end

    assign active_o = (state_q == PG_ACTIVE);
    assign pwr_en_o = (state_q != PG_SLEEP);
    assign ret_o    = (state_q == PG_SLEEP);
    assign state_o  = state_q;

`ifdef SNITCH_DATA_MEM_PG_STATS_EN
    logic [31:0] sleep_cnt_q;

    // Free-running count of cycles spent in SLEEP, wrapping naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sleep_cnt_q <= '0;
        end else if (state_q == PG_SLEEP) begin
            sleep_cnt_q <= sleep_cnt_q + 32'd1;
        end
    end

    assign sleep_cnt_o = sleep_cnt_q;
`else
    assign sleep_cnt_o = '0;
`endif

endmodule

// File: rtl/tc_sram_impl.sv
// rtl/tc_sram_impl.sv - single-port, one-cycle-latency SRAM bank with byte enables
module tc_sram_impl #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ByteWidth = 8,
    parameter type         impl_in_t = logic,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  impl_in_t             impl_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] rdata_q;

    // The macro config only tunes the physical array; the behavioural array ignores it.
    logic unused_cfg;
    assign unused_cfg = ^impl_i;

    // Byte-masked write into the array.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int unsigned i = 0; i < BeWidth; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*ByteWidth +: ByteWidth] <= wdata_i[i*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    // Registered read port gives the one-cycle latency.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (req_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/snitch_data_mem_pg.sv
// rtl/snitch_data_mem_pg.sv - power-gated TCDM bank array top; SNITCH_DATA_MEM_PG_STATS_EN enables sleep statistics
module snitch_data_mem_pg import snitch_data_mem_pkg::*; #(
    parameter int unsigned TCDMDepth       = 1024,
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned NumTotalBanks   = 32,
    parameter int unsigned BanksPerGroup   = 8,
    parameter int unsigned WakeupCycles    = 4,
    parameter int unsigned IdleThreshold   = 16,
    parameter type sram_cfg_t      = sram_cfg_default_t,
    parameter type sram_cfgs_t     = sram_cfgs_default_t,
    parameter type tcdm_mem_addr_t = logic [31:0],
    parameter type strb_t          = logic [NarrowDataWidth/8-1:0],
    parameter type data_t          = logic [NarrowDataWidth-1:0],
    localparam int unsigned NumGroups = calc_num_groups(NumTotalBanks, BanksPerGroup)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  sram_cfgs_t                            sram_cfgs_i,
    input  logic                                  sleep_en_i,
    input  logic [NumGroups-1:0]                  wake_i,
    input  logic [NumTotalBanks-1:0]              mem_req_i,
    output logic [NumTotalBanks-1:0]              mem_gnt_o,
    input  tcdm_mem_addr_t [NumTotalBanks-1:0]    mem_add_i,
    input  logic [NumTotalBanks-1:0]              mem_wen_i,
    input  strb_t [NumTotalBanks-1:0]             mem_be_i,
    input  data_t [NumTotalBanks-1:0]             mem_wdata_i,
    output data_t [NumTotalBanks-1:0]             mem_rdata_o,
    output logic [NumTotalBanks-1:0]              mem_rvalid_o,
    output logic [NumGroups-1:0]                  grp_pwr_en_o,
    output logic [NumGroups-1:0]                  grp_ret_o,
    output logic [NumGroups-1:0][1:0]             grp_state_o,
    output logic [NumGroups-1:0][31:0]            grp_sleep_cnt_o
);

    localparam int unsigned AddrW = (TCDMDepth > 1) ? $clog2(TCDMDepth) : 1;

    logic [NumGroups-1:0]     grp_req;
    logic [NumGroups-1:0]     grp_active;
    logic [NumTotalBanks-1:0] gnt;
    logic [NumTotalBanks-1:0] rvalid_q;
    sram_cfg_t                bank_cfg;

    // Only the low word-address bits select a row; the rest belong to the interconnect.
    logic unused_addr;
    assign unused_addr = ^mem_add_i;

    assign bank_cfg = sram_cfgs_i.tcdm;

    for (genvar g = 0; g < NumGroups; g++) begin : gen_grp
        assign grp_req[g] = |mem_req_i[g*BanksPerGroup +: BanksPerGroup];

        snitch_data_mem_pg_ctrl #(
            .WakeupCycles  (WakeupCycles),
            .IdleThreshold (IdleThreshold)
        ) i_ctrl (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .sleep_en_i  (sleep_en_i),
            .wake_i      (wake_i[g]),
            .req_i       (grp_req[g]),
            .active_o    (grp_active[g]),
            .pwr_en_o    (grp_pwr_en_o[g]),
            .ret_o       (grp_ret_o[g]),
            .state_o     (grp_state_o[g]),
            .sleep_cnt_o (grp_sleep_cnt_o[g])
        );
    end

    // A bank is only selected once its group is fully powered.
    for (genvar b = 0; b < NumTotalBanks; b++) begin : gen_bank
        assign gnt[b] = mem_req_i[b] & grp_active[b / BanksPerGroup];

        tc_sram_impl #(
            .NumWords  (TCDMDepth),
            .DataWidth (NarrowDataWidth),
            .ByteWidth (8),
            .impl_in_t (sram_cfg_t)
        ) i_bank (
            .clk_i   (clk_i),
            .rst_ni  (~rst_i),
            .impl_i  (bank_cfg),
            .req_i   (gnt[b]),
            .we_i    (mem_wen_i[b]),
            .addr_i  (mem_add_i[b][AddrW-1:0]),
            .wdata_i (mem_wdata_i[b]),
            .be_i    (mem_be_i[b]),
            .rdata_o (mem_rdata_o[b])
        );
    end

    // Read-valid follows every granted read by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= gnt & ~mem_wen_i;
        end
    end

    assign mem_gnt_o    = gnt;
    assign mem_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_snitch_data_mem_pg.sv
// tb/tb_snitch_data_mem_pg.sv - self-checking bench for snitch_data_mem_pg
module tb_snitch_data_mem_pg;
    import snitch_data_mem_pkg::*;

    localparam int NB = 32;
    localparam int BPG = 8;
    localparam int NG = 4;
    localparam int WK = 4;
    localparam int THR = 16;
`ifdef SNITCH_DATA_MEM_PG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    sram_cfgs_default_t     cfg;
    logic                   sleep_en;
    logic [NG-1:0]          wake;
    logic [NB-1:0]          req, wen, gnt, rvalid;
    logic [NB-1:0][31:0]    add;
    logic [NB-1:0][7:0]     be;
    logic [NB-1:0][63:0]    wdata, rdata;
    logic [NG-1:0]          pwr, ret;
    logic [NG-1:0][1:0]     st;
    logic [NG-1:0][31:0]    scnt;

    snitch_data_mem_pg #(
        .TCDMDepth(1024), .NarrowDataWidth(64), .NumTotalBanks(NB),
        .BanksPerGroup(BPG), .WakeupCycles(WK), .IdleThreshold(THR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sram_cfgs_i(cfg), .sleep_en_i(sleep_en), .wake_i(wake),
        .mem_req_i(req), .mem_gnt_o(gnt), .mem_add_i(add), .mem_wen_i(wen), .mem_be_i(be),
        .mem_wdata_i(wdata), .mem_rdata_o(rdata), .mem_rvalid_o(rvalid),
        .grp_pwr_en_o(pwr), .grp_ret_o(ret), .grp_state_o(st), .grp_sleep_cnt_o(scnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: per-group mode (0 active, 1 sleep, 2 waking), consecutive idle run,
    // absolute cycle at which a waking group becomes usable, and a word-level memory.
    int                  m_mode [NG];
    int                  m_idle [NG];
    int                  m_ready[NG];
    int unsigned         m_scnt [NG];
    logic [NB-1:0]       m_rv;
    logic [NB-1:0][63:0] m_rd;
    logic [63:0]         mem_m [int];
    int                  cyc = 0;

    logic [NB-1:0]       obs_gnt, obs_rv, last_eg;
    logic [NG-1:0][1:0]  obs_st;
    logic [NG-1:0]       obs_pwr, obs_ret;
    logic [NB-1:0][63:0] obs_rd;
    logic [NG-1:0][31:0] obs_cnt;

    function automatic logic [1:0] enc(input int m);
        return (m == 1) ? 2'b01 : (m == 2) ? 2'b10 : 2'b00;
    endfunction

    function automatic int key_of(input int b, input logic [31:0] a);
        return b * 1024 + int'(a[9:0]);
    endfunction

    task automatic clear_drv();
        req = '0; wen = '0; add = '0; be = '0; wdata = '0; wake = '0;
    endtask

    // One clock cycle: compare everything against the model, then advance the model.
    task automatic step();
        logic [NB-1:0]      eg;
        logic [NG-1:0][1:0] es;
        logic [NG-1:0]      ep, er;
        logic [63:0]        w;
        bit                 anyr;
        int                 k;
        #4;
        for (int b = 0; b < NB; b++) eg[b] = req[b] && (m_mode[b / BPG] == 0);
        for (int g = 0; g < NG; g++) begin
            es[g] = enc(m_mode[g]);
            ep[g] = (m_mode[g] != 1);
            er[g] = (m_mode[g] == 1);
        end
        chk("gnt", gnt, eg);
        chk("state", st, es);
        chk("pwr_en", pwr, ep);
        chk("ret", ret, er);
        chk("rvalid", rvalid, m_rv);
        for (int b = 0; b < NB; b++) if (m_rv[b]) chk("rdata", rdata[b], m_rd[b]);
        for (int g = 0; g < NG; g++) chk("sleep_cnt", scnt[g], STATS ? 32'(m_scnt[g]) : 32'd0);
        obs_gnt = gnt; obs_st = st; obs_pwr = pwr; obs_ret = ret;
        obs_rv = rvalid; obs_rd = rdata; obs_cnt = scnt; last_eg = eg;
        @(posedge clk);
        for (int b = 0; b < NB; b++) begin
            k = key_of(b, add[b]);
            m_rv[b] = eg[b] && !wen[b];
            if (m_rv[b]) m_rd[b] = mem_m.exists(k) ? mem_m[k] : 64'h0;
            if (eg[b] && wen[b]) begin
                w = mem_m.exists(k) ? mem_m[k] : 64'h0;
                for (int j = 0; j < 8; j++) if (be[b][j]) w[j*8 +: 8] = wdata[b][j*8 +: 8];
                mem_m[k] = w;
            end
        end
        for (int g = 0; g < NG; g++) begin
            anyr = |req[g*BPG +: BPG];
            case (m_mode[g])
                0: begin
                    if (!anyr && !wake[g] && sleep_en) begin
                        if (THR != 0 && m_idle[g] >= THR) begin
                            m_mode[g] = 1;
                            m_idle[g] = 0;
                        end else begin
                            m_idle[g]++;
                        end
                    end else begin
                        m_idle[g] = 0;
                    end
                end
                1: begin
                    m_scnt[g]++;
                    if (anyr || wake[g]) begin
                        m_mode[g]  = 2;
                        m_ready[g] = cyc + WK + 1;
                    end
                end
                default: if (cyc + 1 >= m_ready[g]) m_mode[g] = 0;
            endcase
        end
        cyc++;
        #1;
    endtask

    // Reset for one edge with whatever is currently driven, then verify reset values.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_drv();
        for (int g = 0; g < NG; g++) begin
            m_mode[g] = 0; m_idle[g] = 0; m_ready[g] = 0; m_scnt[g] = 0;
        end
        m_rv = '0;
        cyc++;
        #3;
        chk("rst_state", st, '0);
        chk("rst_pwr_en", pwr, 4'hF);
        chk("rst_ret", ret, '0);
        chk("rst_rvalid", rvalid, '0);
        chk("rst_sleep_cnt", scnt, '0);
    endtask

    task automatic background();
        for (int g = 0; g < NG; g++) begin
            if (g != 1) begin
                req[g*BPG] = 1'b1; wen[g*BPG] = 1'b1; add[g*BPG] = 32'd1;
                be[g*BPG] = 8'hFF; wdata[g*BPG] = {$urandom, $urandom};
            end
        end
    endtask

    typedef struct {
        int          bank;
        bit          rq;
        bit          we;
        int          addr;
        logic [63:0] wd;
        bit          eg;
        bit          erv;
        logic [63:0] erd;
    } vec_t;

    vec_t tbl[9];
    bit   busy[NG];
    int   k;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cfg = '0; rst = 1'b1; sleep_en = 1'b0; clear_drv();
        m_rv = '0; m_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        tbl[0] = '{3, 1, 1, 5, 64'hDEAD_BEEF_0123_4567, 1, 0, 64'h0};
        tbl[1] = '{3, 1, 0, 5, 64'h0, 1, 0, 64'h0};
        tbl[2] = '{3, 0, 0, 5, 64'h0, 0, 1, 64'hDEAD_BEEF_0123_4567};
        tbl[3] = '{9, 1, 1, 7, 64'h0011_2233_4455_6677, 1, 0, 64'h0};
        tbl[4] = '{9, 1, 0, 7, 64'h0, 1, 0, 64'h0};
        tbl[5] = '{9, 0, 0, 7, 64'h0, 0, 1, 64'h0011_2233_4455_6677};
        tbl[6] = '{17, 1, 1, 2, 64'hA5A5_5A5A_F00D_CAFE, 1, 0, 64'h0};
        tbl[7] = '{17, 1, 0, 2, 64'h0, 1, 0, 64'h0};
        tbl[8] = '{17, 0, 0, 2, 64'h0, 0, 1, 64'hA5A5_5A5A_F00D_CAFE};
        for (int i = 0; i < 9; i++) begin
            clear_drv();
            req[tbl[i].bank] = tbl[i].rq;
            wen[tbl[i].bank] = tbl[i].we;
            add[tbl[i].bank] = 32'(tbl[i].addr);
            be[tbl[i].bank] = 8'hFF;
            wdata[tbl[i].bank] = tbl[i].wd;
            step();
            chk("tbl_gnt", obs_gnt[tbl[i].bank], tbl[i].eg);
            chk("tbl_rvalid", obs_rv[tbl[i].bank], tbl[i].erv);
            if (tbl[i].erv) chk("tbl_rdata", obs_rd[tbl[i].bank], tbl[i].erd);
        end

        // Group 1 idles while the others stay busy.
        sleep_en = 1'b1;
        repeat (20) begin clear_drv(); background(); step(); end
        chk("idle_state", obs_st, 8'b00_00_01_00);
        chk("idle_pwr_en", obs_pwr, 4'b1101);
        chk("idle_ret", obs_ret, 4'b0010);

        // Read into the sleeping group: four WAKE cycles, grant at t+5, data at t+6.
        clear_drv(); background();
        req[9] = 1'b1; wen[9] = 1'b0; add[9] = 32'd7;
        step();
        chk("wake_gnt_t", obs_gnt[9], 1'b0);
        for (int i = 1; i <= WK; i++) begin
            background(); step();
            chk("wake_state", obs_st[1], 2'b10);
            chk("wake_gnt", obs_gnt[9], 1'b0);
        end
        background(); step();
        chk("wake_gnt_t5", obs_gnt[9], 1'b1);
        clear_drv(); background(); step();
        chk("wake_rvalid_t6", obs_rv[9], 1'b1);
        chk("wake_rdata_t6", obs_rd[9], 64'h0011_2233_4455_6677);

        // Request lands exactly on the threshold-hit cycle.
        clear_drv(); background();
        req[9] = 1'b1; wen[9] = 1'b1; add[9] = 32'd6; be[9] = 8'hFF; wdata[9] = 64'h1357_9BDF_2468_ACE0;
        step();
        repeat (THR) begin clear_drv(); background(); step(); end
        clear_drv(); background();
        req[9] = 1'b1; wen[9] = 1'b0; add[9] = 32'd6;
        step();
        chk("thr_gnt", obs_gnt[9], 1'b1);
        chk("thr_state", obs_st[1], 2'b00);
        clear_drv(); background(); step();
        chk("thr_state_next", obs_st[1], 2'b00);
        chk("thr_rdata", obs_rd[9], 64'h1357_9BDF_2468_ACE0);

        // wake_i and sleep_en_i=0 both hold an idle group awake.
        clear_drv(); sleep_en = 1'b1; wake = 4'b0100;
        repeat (100) step();
        chk("wake_hold_state", obs_st[2], 2'b00);
        wake = '0; sleep_en = 1'b0;
        repeat (100) step();
        chk("sleep_en_hold_state", obs_st[2], 2'b00);

        // Sleep 50 cycles, wake, then reset mid-WAKE.
        do_reset();
        sleep_en = 1'b1;
        k = 0;
        while (k < 100 && obs_st[1] !== 2'b01) begin step(); k++; end
        chk("stats_sleep_reached", obs_st[1], 2'b01);
        repeat (50) step();
        chk("stats_cnt50", obs_cnt[1], STATS ? 32'd50 : 32'd0);
        req[9] = 1'b1; wen[9] = 1'b0; add[9] = 32'd7;
        step();
        step();
        chk("rst_mid_wake_state", obs_st[1], 2'b10);
        do_reset();

        // Reset on the edge after a granted read must drop its rvalid.
        req[3] = 1'b1; wen[3] = 1'b0; add[3] = 32'd5;
        #4;
        chk("rst_read_gnt", gnt[3], 1'b1);
        #1;
        do_reset();

        // Randomized traffic against the model.
        for (int g = 0; g < NG; g++) busy[g] = 1'b0;
        sleep_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < NG; g++) begin
                if ($urandom % 40 == 0) busy[g] = !busy[g];
                wake[g] = ($urandom % 80 == 0);
            end
            if ($urandom % 300 == 0) sleep_en = !sleep_en;
            for (int b = 0; b < NB; b++) begin
                if (!req[b] && busy[b / BPG] && ($urandom % 6 == 0)) begin
                    add[b] = 32'($urandom % 8);
                    k = key_of(b, add[b]);
                    req[b] = 1'b1;
                    if (!mem_m.exists(k) || ($urandom % 2 == 0)) begin
                        wen[b] = 1'b1;
                        wdata[b] = {$urandom, $urandom};
                        be[b] = mem_m.exists(k) ? 8'($urandom) : 8'hFF;
                    end else begin
                        wen[b] = 1'b0;
                    end
                end
            end
            step();
            for (int b = 0; b < NB; b++) if (req[b] && last_eg[b]) req[b] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
